bit_serializer: RTL and testbench

Parallel-to-serial front end for the 1011 sequence-detector path. It accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial output. That output drives the detector's single-bit input directly. A one-word holding buffer lets consecutive words stream with no idle bit between them.

---
 rtl/bit_serializer.sv | 107 ++++++++++
 tb/tb_bit_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the 1011 detector path.
// A one-word holding buffer lets back-to-back words stream without an idle bit.
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_active,
  output logic              frame_start,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] hbuf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hvalid_q;
  logic              ser_bit_q;
  logic              ser_active_q;
  logic              frame_start_q;

  logic              accept;
  logic              last;
  logic              direct_load;
  logic              hbuf_load;
  logic              load;
  logic [DATA_W-1:0] word_d;
  logic              first_bit_d;
  logic [DATA_W-1:0] rest_d;
  logic              shift_bit_d;
  logic [DATA_W-1:0] shift_rest_d;

  assign in_ready    = !hvalid_q && !reset;
  assign accept      = in_valid && in_ready;
  assign last        = (state_q == SHIFT) && (cnt_q == '0);
  // hbuf can only be full when in_ready is low, so the two load sources never collide
  assign direct_load = accept && ((state_q == IDLE) || (last && !hvalid_q));
  assign hbuf_load   = last && hvalid_q;
  assign load        = direct_load || hbuf_load;
  assign word_d      = hbuf_load ? hbuf_q : in_data;

  assign first_bit_d  = LSB_FIRST ? word_d[0] : word_d[DATA_W-1];
  assign rest_d       = LSB_FIRST ? (word_d >> 1) : (word_d << 1);
  assign shift_bit_d  = LSB_FIRST ? sreg_q[0] : sreg_q[DATA_W-1];
  assign shift_rest_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      hbuf_q        <= '0;
      cnt_q         <= '0;
      hvalid_q      <= 1'b0;
      ser_bit_q     <= IDLE_BIT;
      ser_active_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (load) begin
        state_q       <= SHIFT;
        ser_bit_q     <= first_bit_d;
        sreg_q        <= rest_d;
        cnt_q         <= CNT_MAX;
        frame_start_q <= 1'b1;
        ser_active_q  <= 1'b1;
      end else if (state_q == SHIFT) begin
        if (last) begin
          state_q       <= IDLE;
          ser_bit_q     <= IDLE_BIT;
          ser_active_q  <= 1'b0;
          frame_start_q <= 1'b0;
        end else begin
          ser_bit_q     <= shift_bit_d;
          sreg_q        <= shift_rest_d;
          cnt_q         <= cnt_q - 1'b1;
          frame_start_q <= 1'b0;
        end
      end

      if (hbuf_load) begin
        hvalid_q <= 1'b0;
      end else if (accept && !direct_load) begin
        hbuf_q   <= in_data;
        hvalid_q <= 1'b1;
      end
    end
  end

  assign ser_bit     = ser_bit_q;
  assign ser_active  = ser_active_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == SHIFT) || hvalid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: per-cycle vector table on the default
// configuration plus hand sequences for backpressure, reset, LSB-first and IDLE_BIT=1.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default configuration
  logic [7:0] d0;
  logic v0, rdy0, sb0, act0, fs0, bsy0;
  bit_serializer dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
    .ser_bit(sb0), .ser_active(act0), .frame_start(fs0), .busy(bsy0)
  );

  // DATA_W = 4, LSB first
  logic [3:0] d1;
  logic v1, rdy1, sb1, act1, fs1, bsy1;
  bit_serializer #(.DATA_W(4), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .ser_bit(sb1), .ser_active(act1), .frame_start(fs1), .busy(bsy1)
  );

  // idle level high
  logic [7:0] d2;
  logic v2, rdy2, sb2, act2, fs2, bsy2;
  bit_serializer #(.IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .ser_bit(sb2), .ser_active(act2), .frame_start(fs2), .busy(bsy2)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       sb;
    logic       act;
    logic       fs;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic row(input logic v, input logic [7:0] d, input logic rdy, input logic sb,
                     input logic act, input logic fs, input logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.sb = sb; r.act = act; r.fs = fs; r.bsy = bsy;
    tbl.push_back(r);
  endtask

  // Each row: inputs driven this cycle, outputs expected during this cycle.
  task automatic run_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      v0 = tbl[i].v;
      d0 = tbl[i].d;
      #1;
      chk($sformatf("%s[%0d].in_ready", tag, i - lo), rdy0, tbl[i].rdy);
      chk($sformatf("%s[%0d].ser_bit", tag, i - lo), sb0, tbl[i].sb);
      chk($sformatf("%s[%0d].ser_active", tag, i - lo), act0, tbl[i].act);
      chk($sformatf("%s[%0d].frame_start", tag, i - lo), fs0, tbl[i].fs);
      chk($sformatf("%s[%0d].busy", tag, i - lo), bsy0, tbl[i].bsy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b0_bits;
    logic [7:0]  a5_bits;
    logic [7:0]  c3_bits;
    logic [3:0]  lsb_word;
    logic [7:0]  words [3];
    logic [23:0] exp24, got24;
    logic [15:0] exp16, got16;
    int idx, nbits, gaps, rdy_low, gap_bit_bad;

    // single word 8'hB0, indices 0..9
    b0_bits = 8'hB0;
    row(1'b1, 8'hB0, 1, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) row(1'b0, 8'h00, 1, b0_bits[i], 1, (i == 7), 1);
    row(1'b0, 8'h00, 1, 0, 0, 0, 0);

    // back-to-back 8'hA5 then 8'h3C, indices 10..27
    a5_bits = 8'hA5;
    c3_bits = 8'h3C;
    row(1'b1, 8'hA5, 1, 0, 0, 0, 0);
    row(1'b1, 8'h3C, 1, a5_bits[7], 1, 1, 1);
    for (int i = 6; i >= 0; i--) row(1'b0, 8'h00, 0, a5_bits[i], 1, 0, 1);
    for (int i = 7; i >= 0; i--) row(1'b0, 8'h00, 1, c3_bits[i], 1, (i == 7), 1);
    row(1'b0, 8'h00, 1, 0, 0, 0, 0);

    v0 = 0; d0 = '0; v1 = 0; d1 = '0; v2 = 0; d2 = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.in_ready", rdy0, 0);
    chk("reset.ser_bit", sb0, 0);
    chk("reset.ser_active", act0, 0);
    chk("reset.frame_start", fs0, 0);
    chk("reset.busy", bsy0, 0);
    chk("reset.idle_hi_ser_bit", sb2, 1);
    reset = 1'b0;
    #1;
    chk("post_reset.in_ready", rdy0, 1);

    run_rows(0, 9, "single_b0");
    run_rows(10, 27, "b2b_a5_3c");

    // reset mid-word with the holding buffer full
    @(negedge clk); v0 = 1; d0 = 8'hA5;
    @(negedge clk); v0 = 1; d0 = 8'h3C;
    @(negedge clk); v0 = 0;
    @(negedge clk); #1;
    chk("midreset.hvalid_busy", bsy0, 1);
    chk("midreset.in_ready_full", rdy0, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midreset.ser_bit", sb0, 0);
    chk("midreset.ser_active", act0, 0);
    chk("midreset.busy", bsy0, 0);
    chk("midreset.in_ready", rdy0, 0);
    chk("midreset.frame_start", fs0, 0);
    reset = 1'b0;
    run_rows(0, 9, "after_reset_b0");

    // backpressure: three words offered continuously
    words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h96;
    exp24 = {8'hC3, 8'h5A, 8'h96};
    got24 = '0; idx = 0; nbits = 0; gaps = 0; rdy_low = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      v0 = (idx < 3);
      d0 = (idx < 3) ? words[idx] : 8'h00;
      #1;
      if (act0) begin
        got24 = {got24[22:0], sb0};
        nbits++;
      end else if (nbits > 0 && nbits < 24) begin
        gaps++;
      end
      if (idx < 3 && !rdy0) rdy_low++;
      if (v0 && rdy0) idx++;
      if (nbits == 24) break;
    end
    v0 = 0;
    chk("bp.words_accepted", idx, 3);
    chk("bp.bits", nbits, 24);
    chk("bp.gaps", gaps, 0);
    chk("bp.stream", got24, exp24);
    chk("bp.ready_low_cycles", rdy_low, 7);
    @(negedge clk); #1;
    chk("bp.end_idle", act0, 0);

    // LSB-first, 4-bit word
    lsb_word = 4'b1101;
    @(negedge clk); v1 = 1; d1 = lsb_word;
    #1;
    chk("lsb.ready", rdy1, 1);
    @(negedge clk); v1 = 0; #1;
    chk("lsb.frame_start", fs1, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      chk($sformatf("lsb.bit%0d", i), sb1, lsb_word[i]);
      chk($sformatf("lsb.active%0d", i), act1, 1);
    end
    @(negedge clk); #1;
    chk("lsb.end_active", act1, 0);
    chk("lsb.end_busy", bsy1, 0);

    // IDLE_BIT=1 with the second word offered one cycle late
    exp16 = {8'h0F, 8'hF0};
    got16 = '0; nbits = 0; gaps = 0; gap_bit_bad = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      v2 = (cyc == 0) || (cyc == 9);
      d2 = (cyc == 0) ? 8'h0F : 8'hF0;
      #1;
      if (act2) begin
        got16 = {got16[14:0], sb2};
        nbits++;
      end else begin
        if (sb2 !== 1'b1) gap_bit_bad++;
        if (nbits > 0 && nbits < 16) gaps++;
      end
    end
    v2 = 0;
    chk("idlehi.bits", nbits, 16);
    chk("idlehi.gap_cycles", gaps, 1);
    chk("idlehi.idle_level", gap_bit_bad, 0);
    chk("idlehi.stream", got16, exp16);
    chk("idlehi.end_busy", bsy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
